// File: rtl/reg_link_pkg.sv
// Shared types and constants for the UART register-access link.
package reg_link_pkg;

  // Command codes decoded by the inbound parser.
  localparam logic [7:0] CMD_NOP = 8'h00;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;

  // Response type bytes sent back to the host.
  localparam logic [7:0] RESP_WR_ACK  = 8'h81;
  localparam logic [7:0] RESP_RD_DATA = 8'h82;

  typedef struct packed {
    logic [7:0] resp_type;
    logic [7:0] addr;
    logic [7:0] data;
  } resp_frame_t;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_e;

  // Byte of a frame in transmit order: 0=type, 1=addr, 2=data.
  function automatic logic [7:0] frame_byte(resp_frame_t frame, logic [1:0] idx);
    case (idx)
      2'd0:    frame_byte = frame.resp_type;
      2'd1:    frame_byte = frame.addr;
      default: frame_byte = frame.data;
    endcase
  endfunction

endpackage

// File: rtl/reg_resp_tx_if.sv
// Request strobes in, UART tx handshake out, plus status flags.
interface reg_resp_tx_if;
  logic       rd_en_i;
  logic       wr_en_i;
  logic [7:0] reg_addr_i;
  logic [7:0] rd_data_i;
  logic [7:0] wr_data_i;
  logic       tx_done_i;
  logic       tx_start_o;
  logic [7:0] tx_data_o;
  logic       busy_o;
  logic       overflow_o;

  modport slave (
    input  rd_en_i, wr_en_i, reg_addr_i, rd_data_i, wr_data_i, tx_done_i,
    output tx_start_o, tx_data_o, busy_o, overflow_o
  );

  modport master (
    output rd_en_i, wr_en_i, reg_addr_i, rd_data_i, wr_data_i, tx_done_i,
    input  tx_start_o, tx_data_o, busy_o, overflow_o
  );
endinterface

// File: rtl/reg_resp_tx_fifo.sv
// Synchronous FIFO of response frames; one extra pointer bit tells full from empty.
module resp_fifo
  import reg_link_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  resp_frame_t din,
  output resp_frame_t dout,
  output logic        empty,
  output logic        full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  resp_frame_t mem_q [DEPTH];
  logic        do_push, do_pop;

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/reg_resp_tx.sv
// Turns register read/write strobes into 3-byte response frames for the UART tx.
module reg_resp_tx
  import reg_link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  reg_resp_tx_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  resp_frame_t frame_q, frame_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        overflow_q, overflow_d;
  logic        tx_start;

  logic        req, push, pop, fifo_empty, fifo_full;
  resp_frame_t entry, head;

  // Build the response entry; read wins when both strobes fire.
  always_comb begin
    entry.addr = bus.reg_addr_i;
    if (bus.rd_en_i) begin
      entry.resp_type = RESP_RD_DATA;
      entry.data      = bus.rd_data_i;
    end else begin
      entry.resp_type = RESP_WR_ACK;
      entry.data      = bus.wr_data_i;
    end
  end

  assign req        = bus.rd_en_i | bus.wr_en_i;
  assign pop        = (state_q == S_IDLE) & ~fifo_empty;
  assign push       = req & (~fifo_full | pop);
  assign overflow_d = overflow_q | (req & fifo_full & ~pop);

  resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Frame sequencer: next state, byte index and the byte to present on tx_data_o.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          frame_d   = head;
          idx_d     = 2'd0;
          tx_data_d = frame_byte(head, 2'd0);
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        tx_start = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done_i) begin
          if (idx_q == 2'd2) begin
            state_d = S_IDLE;
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = frame_byte(frame_q, idx_q + 2'd1);
            state_d   = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      frame_q    <= '0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.tx_start_o = tx_start;
  assign bus.tx_data_o  = tx_data_q;
  assign bus.busy_o     = (state_q != S_IDLE) | ~fifo_empty;
  assign bus.overflow_o = overflow_q;

endmodule

// File: tb/tb_reg_resp_tx.sv
// Scoreboard bench for reg_resp_tx with a behavioural UART tx responder.
module tb_reg_resp_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_resp_tx_if bus ();
  logic done_resp = 1'b0;
  logic done_extra = 1'b0;
  assign bus.tx_done_i = done_resp | done_extra;

  reg_resp_tx #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int start_cyc[$];
  int done_delay = 10;
  int done_cnt = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART tx model: every start pops the scoreboard, done follows done_delay cycles later.
  initial forever begin
    @(posedge clk);
    #1;
    done_resp = 1'b0;
    if (done_cnt > 0) done_cnt--;
    if (done_cnt == 0) begin
      done_resp = 1'b1;
      done_cnt  = -1;
    end
    @(negedge clk);
    if (bus.tx_start_o === 1'b1) begin
      start_cyc.push_back(cyc);
      check_eq("start_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("tx_byte", 32'(bus.tx_data_o), 32'(exp_q.pop_front()));
      done_cnt = done_delay;
    end
  end

  // Drive one request cycle; called and returning just after a rising edge.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] rdat, input logic [7:0] wdat, input bit accept);
    bus.rd_en_i    = rd;
    bus.wr_en_i    = wr;
    bus.reg_addr_i = a;
    bus.rd_data_i  = rdat;
    bus.wr_data_i  = wdat;
    if (accept) begin
      exp_q.push_back(rd ? 8'h82 : 8'h81);
      exp_q.push_back(a);
      exp_q.push_back(rd ? rdat : wdat);
    end
    @(posedge clk);
    #1;
    bus.rd_en_i = 1'b0;
    bus.wr_en_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int idle_cyc);
    bit ok;
    ok = 1'b0;
    idle_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.busy_o === 1'b0 && exp_q.size() == 0) begin
        ok = 1'b1;
        idle_cyc = cyc;
        break;
      end
    end
    check_eq("wait_idle", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cyc, ic, target;
    bus.rd_en_i = 1'b0;
    bus.wr_en_i = 1'b0;
    bus.reg_addr_i = 8'h00;
    bus.rd_data_i = 8'h00;
    bus.wr_data_i = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tx_start", 32'(bus.tx_start_o), 0);
    check_eq("rst_tx_data", 32'(bus.tx_data_o), 0);
    check_eq("rst_busy", 32'(bus.busy_o), 0);
    check_eq("rst_overflow", 32'(bus.overflow_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single read with latency and busy timing
    done_delay = 10;
    start_cyc.delete();
    req_cyc = cyc;
    do_req(1'b1, 1'b0, 8'h10, 8'hA5, 8'h00, 1'b1);
    wait_idle(200, ic);
    check_eq("rd_nstarts", 32'(start_cyc.size()), 3);
    check_eq("rd_first_lat", 32'(start_cyc[0] - req_cyc), 2);
    check_eq("rd_gap1", 32'(start_cyc[1] - start_cyc[0]), 11);
    check_eq("rd_gap2", 32'(start_cyc[2] - start_cyc[1]), 11);
    check_eq("rd_busy_drop", 32'(ic - start_cyc[2]), 11);

    // Single write
    start_cyc.delete();
    do_req(1'b0, 1'b1, 8'h03, 8'h00, 8'h7F, 1'b1);
    wait_idle(200, ic);
    check_eq("wr_nstarts", 32'(start_cyc.size()), 3);
    check_eq("wr_overflow", 32'(bus.overflow_o), 0);

    // Burst: five fit (one popped at once, four queued), the sixth is dropped
    done_delay = 100;
    start_cyc.delete();
    do_req(1'b1, 1'b0, 8'h20, 8'h01, 8'h00, 1'b1);
    do_req(1'b0, 1'b1, 8'h21, 8'h00, 8'h02, 1'b1);
    do_req(1'b1, 1'b0, 8'h22, 8'h03, 8'h00, 1'b1);
    do_req(1'b0, 1'b1, 8'h23, 8'h00, 8'h04, 1'b1);
    do_req(1'b1, 1'b0, 8'h24, 8'h05, 8'h00, 1'b1);
    do_req(1'b1, 1'b0, 8'h25, 8'h06, 8'h00, 1'b0);
    @(negedge clk);
    check_eq("burst_overflow_set", 32'(bus.overflow_o), 1);
    for (int i = 0; i < 2000 && start_cyc.size() < 3; i++) @(negedge clk);
    check_eq("burst_third_start", 32'(start_cyc.size() >= 3), 1);
    // Request lands in the cycle the full FIFO pops its head: must be accepted
    target = start_cyc[2] + 101;
    for (int i = 0; i < 500 && cyc < target; i++) begin
      @(posedge clk);
      #1;
    end
    do_req(1'b0, 1'b1, 8'h5A, 8'h00, 8'hC3, 1'b1);
    wait_idle(5000, ic);
    check_eq("burst_nstarts", 32'(start_cyc.size()), 18);
    check_eq("burst_overflow_sticky", 32'(bus.overflow_o), 1);

    // Simultaneous strobes: read wins
    done_delay = 10;
    start_cyc.delete();
    do_req(1'b1, 1'b1, 8'h22, 8'h11, 8'h99, 1'b1);
    wait_idle(200, ic);
    check_eq("both_nstarts", 32'(start_cyc.size()), 3);

    // Spurious done while idle
    start_cyc.delete();
    done_extra = 1'b1;
    @(posedge clk);
    #1;
    done_extra = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("spurious_nstarts", 32'(start_cyc.size()), 0);
    check_eq("spurious_busy", 32'(bus.busy_o), 0);

    // Done held off: stays in S_WAIT with no extra starts
    done_delay = 1100;
    start_cyc.delete();
    do_req(1'b1, 1'b0, 8'h31, 8'h62, 8'h00, 1'b1);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check_eq("hold_nstarts", 32'(start_cyc.size()), 1);
    check_eq("hold_busy", 32'(bus.busy_o), 1);
    check_eq("hold_tx_start", 32'(bus.tx_start_o), 0);
    wait_idle(4000, ic);
    check_eq("hold_final_nstarts", 32'(start_cyc.size()), 3);

    // Reset after the second byte's start
    done_delay = 10;
    start_cyc.delete();
    do_req(1'b1, 1'b0, 8'h70, 8'h0F, 8'h00, 1'b1);
    for (int i = 0; i < 200 && start_cyc.size() < 2; i++) @(negedge clk);
    check_eq("mid_second_start", 32'(start_cyc.size()), 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    done_cnt = -1;
    exp_q.delete();
    #1;
    check_eq("mid_rst_tx_start", 32'(bus.tx_start_o), 0);
    check_eq("mid_rst_tx_data", 32'(bus.tx_data_o), 0);
    check_eq("mid_rst_busy", 32'(bus.busy_o), 0);
    check_eq("mid_rst_overflow", 32'(bus.overflow_o), 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid_rst_nstarts", 32'(start_cyc.size()), 2);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_cyc.delete();
    req_cyc = cyc;
    do_req(1'b1, 1'b0, 8'h44, 8'h55, 8'h00, 1'b1);
    wait_idle(200, ic);
    check_eq("post_rst_nstarts", 32'(start_cyc.size()), 3);
    check_eq("post_rst_lat", 32'(start_cyc[0] - req_cyc), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
